// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encodings and sizing constants.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Width of the shared hold/wait/gap counter.
  localparam int CNT_W      = 32;
  // Largest number of sequenced stages; sizes the stage index register.
  localparam int MAX_STAGES = 16;
  localparam int IDX_W      = $clog2(MAX_STAGES);

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset synchronizer with configurable depth.
module reset_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  // Shift a constant one through the chain once rst_n is released.
  always_comb begin
    sync_d    = '0;
    sync_d[0] = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Chain clears immediately on rst_n, releases one flop per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_rst_n = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets one at a time after the board reset is
// synchronized, waiting for each stage's ready (or a timeout) in between.
//
// state | meaning
// HOLD  | all stage resets asserted, counting the post-release hold time
// WAIT  | stage idx released, waiting for its ready or the timeout
// GAP   | idle spacing before releasing the next stage
// DONE  | every stage released; stage_ready is ignored from here on
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int          NUM_STAGES    = 4,
  parameter int          HOLD_CYCLES   = 16,
  parameter int          STAGE_GAP     = 4,
  parameter logic [31:0] READY_TIMEOUT = 32'h0000FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_ready,
  output logic                  busy,
  output logic [NUM_STAGES-1:0] timeout_err
);

  // A zero hold would skip HOLD entirely, so it is stretched to one cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_CYCLES <= 1) ? '0 : CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  logic                  sync_rst_n;
  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      idx_next;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic [NUM_STAGES-1:0] timeout_err_q, timeout_err_d;
  logic                  all_ready_q, all_ready_d;
  logic                  busy_q;
  logic                  ready_cur;

  reset_sync #(.DEPTH(2)) u_reset_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_rst_n (sync_rst_n)
  );

  // Next-state logic: soft request overrides everything, then the FSM proper.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_rst_d   = stage_rst_q;
    timeout_err_d = timeout_err_q;
    all_ready_d   = all_ready_q;
    cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    idx_next      = idx_q + 1'b1;

    // Select the ready bit of the stage currently being waited on.
    ready_cur = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ready_cur = stage_ready[i];
      end
    end

    if (sync_rst_n) begin
      if (soft_rst_req) begin
        state_d     = ST_HOLD;
        cnt_d       = '0;
        idx_d       = '0;
        stage_rst_d = '1;
        all_ready_d = 1'b0;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (cnt_q >= HOLD_LAST) begin
              state_d        = ST_WAIT;
              cnt_d          = '0;
              idx_d          = '0;
              stage_rst_d[0] = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ST_WAIT: begin
            if (ready_cur) begin
              state_d = ST_GAP;
              cnt_d   = '0;
            end else if (cnt_q >= READY_TIMEOUT) begin
              // The stage stays released; the flag just records the late ready.
              for (int i = 0; i < NUM_STAGES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                  timeout_err_d[i] = 1'b1;
                end
              end
              state_d = ST_GAP;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ST_GAP: begin
            if (cnt_q >= GAP_LAST) begin
              cnt_d = '0;
              if (idx_q < LAST_IDX) begin
                idx_d   = idx_next;
                state_d = ST_WAIT;
                for (int i = 0; i < NUM_STAGES; i++) begin
                  if (idx_next == IDX_W'(i)) begin
                    stage_rst_d[i] = 1'b0;
                  end
                end
              end else begin
                state_d     = ST_DONE;
                all_ready_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ST_DONE: begin
            state_d = ST_DONE;
          end
          default: begin
            state_d = ST_HOLD;
          end
        endcase
      end
    end
  end

  // FSM, counter, index and output registers; rst_n forces reset values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_rst_q   <= '1;
      timeout_err_q <= '0;
      all_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_rst_q   <= stage_rst_d;
      timeout_err_q <= timeout_err_d;
      all_ready_q   <= all_ready_d;
      busy_q        <= ~all_ready_d;
    end
  end

  assign stage_rst   = stage_rst_q;
  assign all_ready   = all_ready_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: three instances cover the default
// sequence, the ready timeout with soft re-sequence, and the minimal config.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Instance A: defaults, ready either auto (delayed ~stage_rst) or manual.
  logic       rst_n_a = 1'b1;
  logic       soft_a  = 1'b0;
  logic       auto_a  = 1'b1;
  logic [3:0] man_a   = 4'b0000;
  logic [3:0] d1_a    = 4'b0000;
  logic [3:0] d2_a    = 4'b0000;
  logic [3:0] ready_a;
  logic [3:0] stage_rst_a;
  logic [3:0] terr_a;
  logic       all_ready_a;
  logic       busy_a;

  // Instance B: READY_TIMEOUT = 10, stage 1 never reports ready.
  logic       rst_n_b = 1'b1;
  logic       soft_b  = 1'b0;
  logic [3:0] d1_b    = 4'b0000;
  logic [3:0] d2_b    = 4'b0000;
  logic [3:0] ready_b;
  logic [3:0] stage_rst_b;
  logic [3:0] terr_b;
  logic       all_ready_b;
  logic       busy_b;

  // Instance C: one stage, zero hold, zero gap.
  logic       rst_n_c = 1'b1;
  logic       soft_c  = 1'b0;
  logic [0:0] ready_c = 1'b0;
  logic [0:0] stage_rst_c;
  logic [0:0] terr_c;
  logic       all_ready_c;
  logic       busy_c;

  // Ready seen at edge n reflects ~stage_rst as it was after edge n-3.
  always @(posedge clk) begin
    d1_a <= ~stage_rst_a;
    d2_a <= d1_a;
    d1_b <= ~stage_rst_b;
    d2_b <= d1_b;
  end

  assign ready_a = auto_a ? d2_a : man_a;
  assign ready_b = d2_b & 4'b1101;

  reset_sequencer dut_a (
    .clk          (clk),
    .rst_n        (rst_n_a),
    .soft_rst_req (soft_a),
    .stage_ready  (ready_a),
    .stage_rst    (stage_rst_a),
    .all_ready    (all_ready_a),
    .busy         (busy_a),
    .timeout_err  (terr_a)
  );

  reset_sequencer #(.READY_TIMEOUT(32'd10)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n_b),
    .soft_rst_req (soft_b),
    .stage_ready  (ready_b),
    .stage_rst    (stage_rst_b),
    .all_ready    (all_ready_b),
    .busy         (busy_b),
    .timeout_err  (terr_b)
  );

  reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(0), .STAGE_GAP(0)) dut_c (
    .clk          (clk),
    .rst_n        (rst_n_c),
    .soft_rst_req (soft_c),
    .stage_ready  (ready_c),
    .stage_rst    (stage_rst_c),
    .all_ready    (all_ready_c),
    .busy         (busy_c),
    .timeout_err  (terr_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Default sequence on instance A: releases at E17/E25/E33/E41, done at E49.
  task automatic run_default_a();
    logic [3:0] exp_rst;
    @(negedge clk);
    rst_n_a = 1'b1;
    for (int n = 0; n <= 52; n++) begin
      @(posedge clk);
      #1;
      if (n < 17)      exp_rst = 4'b1111;
      else if (n < 25) exp_rst = 4'b1110;
      else if (n < 33) exp_rst = 4'b1100;
      else if (n < 41) exp_rst = 4'b1000;
      else             exp_rst = 4'b0000;
      chk($sformatf("a_rst_E%0d", n), 32'(stage_rst_a), 32'(exp_rst));
      chk($sformatf("a_all_ready_E%0d", n), 32'(all_ready_a), 32'(n >= 49));
      chk($sformatf("a_busy_E%0d", n), 32'(busy_a), 32'(n < 49));
      chk($sformatf("a_terr_E%0d", n), 32'(terr_a), 32'h0);
    end
  endtask

  initial begin
    logic [3:0] exp_b;

    #1;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    rst_n_c = 1'b0;
    #2;
    chk("a_reset_rst", 32'(stage_rst_a), 32'hF);
    chk("a_reset_all_ready", 32'(all_ready_a), 32'h0);
    chk("a_reset_busy", 32'(busy_a), 32'h1);
    chk("a_reset_terr", 32'(terr_a), 32'h0);
    chk("c_reset_rst", 32'(stage_rst_c), 32'h1);

    // Default sequence.
    run_default_a();

    // Soft re-sequence from DONE, then manual ready.
    auto_a = 1'b0;
    man_a  = 4'b0000;
    @(negedge clk);
    soft_a = 1'b1;
    @(posedge clk);
    #1;
    soft_a = 1'b0;
    chk("a_soft_rst", 32'(stage_rst_a), 32'hF);
    chk("a_soft_busy", 32'(busy_a), 32'h1);
    chk("a_soft_all_ready", 32'(all_ready_a), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("a_soft_hold_%0d", k), 32'(stage_rst_a), (k == 16) ? 32'hE : 32'hF);
    end

    // Soft request and ready on the same edge: soft wins, no advance.
    @(negedge clk);
    man_a  = 4'b0001;
    soft_a = 1'b1;
    @(posedge clk);
    #1;
    soft_a = 1'b0;
    man_a  = 4'b0000;
    chk("a_collide_rst", 32'(stage_rst_a), 32'hF);
    chk("a_collide_busy", 32'(busy_a), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("a_collide_hold_%0d", k), 32'(stage_rst_a), (k == 16) ? 32'hE : 32'hF);
    end

    // Ready for stage 0 enters GAP; drop rst_n mid-cycle inside GAP.
    @(negedge clk);
    man_a = 4'b0001;
    @(posedge clk);
    #1;
    chk("a_gap_rst", 32'(stage_rst_a), 32'hE);
    @(posedge clk);
    #3;
    rst_n_a = 1'b0;
    #1;
    chk("a_async_rst", 32'(stage_rst_a), 32'hF);
    chk("a_async_all_ready", 32'(all_ready_a), 32'h0);
    chk("a_async_busy", 32'(busy_a), 32'h1);
    chk("a_async_terr", 32'(terr_a), 32'h0);
    man_a  = 4'b0000;
    auto_a = 1'b1;
    run_default_a();

    // Instance B: stage 1 times out at E36, stage 2 released at E41.
    @(negedge clk);
    rst_n_b = 1'b1;
    for (int n = 0; n <= 41; n++) begin
      @(posedge clk);
      #1;
      if (n < 17)      exp_b = 4'b1111;
      else if (n < 25) exp_b = 4'b1110;
      else if (n < 41) exp_b = 4'b1100;
      else             exp_b = 4'b1000;
      chk($sformatf("b_rst_E%0d", n), 32'(stage_rst_b), 32'(exp_b));
      chk($sformatf("b_terr_E%0d", n), 32'(terr_b), (n >= 36) ? 32'h2 : 32'h0);
      chk($sformatf("b_all_ready_E%0d", n), 32'(all_ready_b), 32'h0);
    end

    // Soft pulse while waiting on stage 2; timeout flag must survive.
    @(negedge clk);
    soft_b = 1'b1;
    @(posedge clk);
    #1;
    soft_b = 1'b0;
    chk("b_soft_rst", 32'(stage_rst_b), 32'hF);
    chk("b_soft_busy", 32'(busy_b), 32'h1);
    chk("b_soft_all_ready", 32'(all_ready_b), 32'h0);
    chk("b_soft_terr", 32'(terr_b), 32'h2);
    for (int k = 1; k <= 58; k++) begin
      @(posedge clk);
      #1;
      if (k < 16)      exp_b = 4'b1111;
      else if (k < 24) exp_b = 4'b1110;
      else if (k < 40) exp_b = 4'b1100;
      else if (k < 48) exp_b = 4'b1000;
      else             exp_b = 4'b0000;
      chk($sformatf("b_reseq_rst_%0d", k), 32'(stage_rst_b), 32'(exp_b));
      chk($sformatf("b_reseq_terr_%0d", k), 32'(terr_b), 32'h2);
      chk($sformatf("b_reseq_all_ready_%0d", k), 32'(all_ready_b), 32'(k >= 56));
      chk($sformatf("b_reseq_busy_%0d", k), 32'(busy_b), 32'(k < 56));
    end

    // Instance C: release at E2, ready sampled at E4, done at E5.
    @(negedge clk);
    rst_n_c = 1'b1;
    for (int n = 0; n <= 6; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("c_rst_E%0d", n), 32'(stage_rst_c), 32'(n < 2));
      chk($sformatf("c_all_ready_E%0d", n), 32'(all_ready_c), 32'(n >= 5));
      chk($sformatf("c_busy_E%0d", n), 32'(busy_c), 32'(n < 5));
      chk($sformatf("c_terr_E%0d", n), 32'(terr_c), 32'h0);
      if (n == 3) ready_c = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Receives the board-level asynchronous active-low reset, synchronizes its release to `clk`, and releases up to `NUM_STAGES` downstream active-high block resets one at a time in index order. Each stage must report ready, or time out, before the next stage is released. It sits between the board reset pin and the per-subsystem `rst` inputs: bus core, memory controller, peripherals and so on. It also supports a synchronous software-requested re-sequence.

## Interface
Parameters:
- `NUM_STAGES`, 4: number of sequenced reset outputs, legal range 1..16.
- `HOLD_CYCLES`, 16: cycles all stage resets stay asserted after synchronized release. A value of 0 is treated as 1.
- `STAGE_GAP`, 4: idle cycles between one stage's ready/timeout and the next stage's release. 0 is legal.
- `READY_TIMEOUT`, 32'h0000FFFF: maximum cycles to wait for `stage_ready[i]`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `soft_rst_req`  in  1  synchronous re-sequence request, sampled on each edge.
- `stage_ready`  in  NUM_STAGES  per-stage "out of reset and ready", synchronous to `clk`.
- `stage_rst`  out  NUM_STAGES  per-stage active-high reset.
- `all_ready`  out  1  all stages released and sequence complete.
- `busy`  out  1  sequence in progress.
- `timeout_err`  out  NUM_STAGES  sticky per-stage timeout flag.

## Operation
- Reset release path: `rst_n` feeds an internal 2-flop synchronizer (asynchronous assert, synchronous deassert) producing `sync_rst_n`.
- Register values while `rst_n` is low (applied asynchronously):
  - `stage_rst` = all ones; `all_ready` = 0; `busy` = 1; `timeout_err` = 0.
  - FSM = HOLD, counter = 0.
- FSM states:
  - HOLD: counts `HOLD_CYCLES` cycles with all `stage_rst` asserted, then clears `stage_rst[0]` and enters WAIT with idx = 0.
  - WAIT: increments the counter each cycle.
    - On `stage_ready[idx]` = 1: go to GAP.
    - If the counter reaches `READY_TIMEOUT` first: set `timeout_err[idx]`, then go to GAP. The stage stays released.
  - GAP: counts `STAGE_GAP` cycles.
    - If idx < NUM_STAGES-1: increment idx, clear `stage_rst[idx]`, enter WAIT.
    - Otherwise: enter DONE.
  - DONE: `all_ready` = 1, `busy` = 0. Changes to `stage_ready` are ignored.
- Counter: 32 bits, cleared on every state entry; the counter never wraps.
- `stage_rst` is monotonic within a sequence: once a bit is cleared it stays cleared until `rst_n` or `soft_rst_req`.
- `soft_rst_req` = 1 in any state, at any edge where `sync_rst_n` = 1:
  - Next edge: `stage_rst` = all ones, `all_ready` = 0, `busy` = 1, FSM = HOLD, counter = 0.
  - It takes priority over a simultaneous `stage_ready` or timeout in the same cycle.
  - Held high, it keeps the FSM in HOLD.
  - `timeout_err` is not cleared; only `rst_n` clears it.
- `rst_n` asserting mid-sequence immediately (asynchronously) returns every output to its reset value.

## Timing
- Edge numbering: E0 is the first rising edge that samples `rst_n` = 1. `sync_rst_n` = 1 after E1.
- `stage_rst[0]` clears after edge E(1+HOLD_CYCLES).
- `stage_ready[i]` sampled high at edge Er → `stage_rst[i+1]` clears after edge Er+STAGE_GAP+1.
  - With `STAGE_GAP` = 0, it clears one edge after ready.
- Timeout: `timeout_err[i]` sets at the edge where the WAIT counter equals `READY_TIMEOUT`, i.e. `READY_TIMEOUT`+1 cycles after the release of stage i.
- `all_ready` rises STAGE_GAP+1 edges after the last stage's ready or timeout.
- `busy` always equals the inverse of `all_ready`.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package/include `reset_seq_pkg`:
  - FSM state encodings (HOLD, WAIT, GAP, DONE).
  - Counter width constant (32).
  - `NUM_STAGES` upper bound (16).
- Sub-module `reset_sync`: parameterizable-depth (default 2) async-assert/sync-deassert synchronizer. It is reusable by other clock domains.
- The top level holds the FSM, the counter, the idx register and the output registers.

## Test plan
- Defaults, all `stage_ready` tied to their own `~stage_rst` delayed 3 cycles:
  - `stage_rst[0]` clears at E17; each later stage clears 8 edges after the previous one.
  - `all_ready` = 1 after the last stage; `timeout_err` = 0.
- `READY_TIMEOUT` = 10, `stage_ready[1]` held 0:
  - `timeout_err` = 4'b0010.
  - Stage 2 is released 11+5 edges after stage 1's release.
  - `all_ready` still reaches 1.
- `soft_rst_req` pulsed for 1 cycle while in WAIT for stage 2:
  - Next edge: `stage_rst` = 4'b1111, `busy` = 1.
  - Re-sequence restarts with HOLD (16 cycles).
  - `timeout_err` is unchanged.
- `soft_rst_req` and `stage_ready[idx]` high on the same edge → soft reset wins; no stage advance.
- `rst_n` pulsed low asynchronously, mid-clock, during GAP:
  - Outputs go to reset values before the next edge.
  - Release timing matches the first scenario.
- `HOLD_CYCLES` = 0, `STAGE_GAP` = 0, `NUM_STAGES` = 1: `stage_rst[0]` clears at E2; `all_ready` rises 1 edge after `stage_ready[0]`.
